// File: rtl/triplet_pkg.sv
// Shared types and helpers for the triplet sampler and its output FIFO.
// Optional per-entry disagree bit is enabled by TRIPLET_DISAGREE_EN.
package triplet_pkg;

   localparam int ERR_CNT_W = 8;

   typedef struct packed {
`ifdef TRIPLET_DISAGREE_EN
      logic       disagree;
`endif
      logic [2:0] trip;
      logic       vote;
   } triplet_entry_t;

   function automatic logic vote3(input logic [2:0] a);
      return a[0] ? (a[1] | a[2]) : (a[1] & a[2]);
   endfunction

endpackage

// File: rtl/triplet_fifo.sv
// Synchronous FIFO of triplet entries; DEPTH must be a power of two (>= 2).
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module triplet_fifo import triplet_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  triplet_entry_t wr_data,
   input  logic           pop,
   output triplet_entry_t rd_data,
   output logic           full,
   output logic           empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   triplet_entry_t mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage is cleared on reset so the head reads as zero while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/triplet_sampler.sv
// Oversampling front end: captures three mid-bit samples per bit period and queues
// them with their majority vote. TRIPLET_DISAGREE_EN adds disagree flag and err_cnt.
module triplet_sampler import triplet_pkg::*; #(
   parameter int DIV   = 8,
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       en,
   output logic [2:0] trip,
   output logic       vote,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overflow
`ifdef TRIPLET_DISAGREE_EN
   ,
   output logic                 disagree,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PH_S0   = PW'(DIV/2 - 1);
   localparam logic [PW-1:0] PH_S1   = PW'(DIV/2);
   localparam logic [PW-1:0] PH_S2   = PW'(DIV/2 + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

   logic           din_m;
   logic           din_s;
   logic [PW-1:0]  phase;
   logic [2:0]     trip_r;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           push_drop;
   triplet_entry_t wr_entry;
   triplet_entry_t head;

   always_ff @(posedge clk) begin
      if (rst) begin
         din_m <= 1'b0;
         din_s <= 1'b0;
      end else begin
         din_m <= din;
         din_s <= din_m;
      end
   end

   // Dropping en restarts the bit period; a partial triplet is simply overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= '0;
         trip_r <= '0;
      end else if (!en) begin
         phase <= '0;
      end else begin
         phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         if (phase == PH_S0) trip_r[0] <= din_s;
         if (phase == PH_S1) trip_r[1] <= din_s;
         if (phase == PH_S2) trip_r[2] <= din_s;
      end
   end

   assign push      = en && (phase == PH_LAST);
   assign pop       = out_valid && out_ready;
   assign push_drop = push && full && !pop;

   always_comb begin
      wr_entry      = '0;
      wr_entry.trip = trip_r;
      wr_entry.vote = vote3(trip_r);
`ifdef TRIPLET_DISAGREE_EN
      wr_entry.disagree = (trip_r != 3'b000) && (trip_r != 3'b111);
`endif
   end

   triplet_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   assign out_valid = !empty;
   assign trip      = head.trip;
   assign vote      = head.vote;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push_drop) begin
         overflow <= 1'b1;
      end
   end

`ifdef TRIPLET_DISAGREE_EN
   logic push_ok;

   assign push_ok  = push && !push_drop;
   assign disagree = head.disagree;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (push_ok && wr_entry.disagree && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_triplet_sampler.sv
// Directed bench for triplet_sampler with DIV=8, DEPTH=4.
// Disagree/err_cnt checks follow TRIPLET_DISAGREE_EN, matching the DUT build.
module tb_triplet_sampler;
   import triplet_pkg::*;

   logic       clk;
   logic       rst;
   logic       din;
   logic       en;
   logic [2:0] trip;
   logic       vote;
   logic       out_valid;
   logic       out_ready;
   logic       overflow;
`ifdef TRIPLET_DISAGREE_EN
   logic       disagree;
   logic [7:0] err_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   triplet_sampler #(
      .DIV   (8),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .en        (en),
      .trip      (trip),
      .vote      (vote),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow)
`ifdef TRIPLET_DISAGREE_EN
      ,
      .disagree  (disagree),
      .err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic maj(input logic [2:0] a);
      return (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_entry(input string tag, input logic [2:0] a);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".trip"}, 32'(trip), 32'(a));
      check({tag, ".vote"}, 32'(vote), 32'(maj(a)));
`ifdef TRIPLET_DISAGREE_EN
      check({tag, ".disagree"}, 32'(disagree), 32'((a != 3'b000) && (a != 3'b111)));
`endif
   endtask

   task automatic check_err(input string tag, input int exp);
`ifdef TRIPLET_DISAGREE_EN
      check(tag, 32'(err_cnt), 32'(exp));
`else
      if (exp < 0) $display("note: %s unused", tag);
`endif
   endtask

   // One bit period starting at phase 0; samples at phases 3,4,5 see din driven
   // before edges 1,2,3 of the period. out_ready is rdy from edge 1, rdy_last at edge 7.
   task automatic run_bit(input logic [2:0] a, input logic fill,
                          input logic rdy, input logic rdy_last);
      for (int i = 0; i < 8; i++) begin
         if (i == 1) out_ready = rdy;
         if (i == 7) out_ready = rdy_last;
         case (i)
            1:       din = a[0];
            2:       din = a[1];
            3:       din = a[2];
            default: din = fill;
         endcase
         tick();
      end
   endtask

   task automatic drain4(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                         input logic [2:0] e2, input logic [2:0] e3);
      logic [2:0] exp_q [4];
      exp_q[0] = e0;
      exp_q[1] = e1;
      exp_q[2] = e2;
      exp_q[3] = e3;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_entry($sformatf("%s[%0d]", tag, k), exp_q[k]);
         tick();
      end
      check({tag, ".empty"}, 32'(out_valid), 32'd0);
   endtask

   task automatic realign();
      en = 1'b0;
      tick();
      en = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      din       = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.trip", 32'(trip), 32'd0);
      check("rst.vote", 32'(vote), 32'd0);
      check("rst.overflow", 32'(overflow), 32'd0);
`ifdef TRIPLET_DISAGREE_EN
      check("rst.disagree", 32'(disagree), 32'd0);
`endif
      check_err("rst.err_cnt", 0);

      // Constant line
      rst       = 1'b0;
      en        = 1'b1;
      din       = 1'b1;
      out_ready = 1'b1;
      repeat (7) tick();
      check("const.no_early_valid", 32'(out_valid), 32'd0);
      tick();
      check_entry("const.bit0", 3'b111);
      run_bit(3'b111, 1'b1, 1'b1, 1'b1);
      check_entry("const.bit1", 3'b111);

      // Exhaustive patterns
      for (int p = 0; p < 8; p++) begin
         run_bit(3'(p), 1'b0, 1'b1, 1'b1);
         check_entry($sformatf("pat%0d", p), 3'(p));
      end
      check_err("pat.err_cnt", 6);

      // Full with simultaneous pop
      run_bit(3'b011, 1'b0, 1'b0, 1'b0);
      run_bit(3'b101, 1'b0, 1'b0, 1'b0);
      run_bit(3'b000, 1'b0, 1'b0, 1'b0);
      run_bit(3'b111, 1'b0, 1'b0, 1'b0);
      check_entry("full.head", 3'b011);
      run_bit(3'b110, 1'b0, 1'b0, 1'b1);
      check("full.overflow", 32'(overflow), 32'd0);
      check_err("full.err_cnt", 9);
      drain4("full.drain", 3'b101, 3'b000, 3'b111, 3'b110);
      realign();

      // Backpressure
      run_bit(3'b001, 1'b0, 1'b0, 1'b0);
      run_bit(3'b010, 1'b0, 1'b0, 1'b0);
      run_bit(3'b100, 1'b0, 1'b0, 1'b0);
      run_bit(3'b110, 1'b0, 1'b0, 1'b0);
      check("bp.overflow_at_4", 32'(overflow), 32'd0);
      run_bit(3'b011, 1'b0, 1'b0, 1'b0);
      check("bp.overflow_at_5", 32'(overflow), 32'd1);
      check_err("bp.err_cnt", 13);
      drain4("bp.drain", 3'b001, 3'b010, 3'b100, 3'b110);
      check("bp.overflow_sticky", 32'(overflow), 32'd1);
      realign();

      // Enable drop mid-bit
      run_bit(3'b101, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         din = (i >= 1) ? 1'b1 : 1'b0;
         tick();
      end
      en = 1'b0;
      repeat (3) tick();
      check_entry("endrop.kept", 3'b101);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         out_ready = (i >= 1) ? 1'b1 : 1'b0;
         case (i)
            1:       din = 1'b1;
            2:       din = 1'b1;
            default: din = 1'b0;
         endcase
         tick();
         if (i >= 1 && i <= 6) check($sformatf("endrop.idle%0d", i), 32'(out_valid), 32'd0);
      end
      check_entry("endrop.next", 3'b011);
      check_err("endrop.err_cnt", 15);

      // Reset mid-operation
      out_ready = 1'b0;
      run_bit(3'b110, 1'b0, 1'b0, 1'b0);
      check("rstmid.pre_valid", 32'(out_valid), 32'd1);
      check("rstmid.pre_overflow", 32'(overflow), 32'd1);
      rst = 1'b1;
      tick();
      check("rstmid.valid", 32'(out_valid), 32'd0);
      check("rstmid.overflow", 32'(overflow), 32'd0);
      check("rstmid.trip", 32'(trip), 32'd0);
      check_err("rstmid.err_cnt", 0);
      rst = 1'b0;
      en  = 1'b1;
      din = 1'b1;
      repeat (7) tick();
      check("rstmid.no_early_valid", 32'(out_valid), 32'd0);
      tick();
      check_entry("rstmid.first", 3'b111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/triplet_sampler.md
# triplet_sampler

Oversampling front end that feeds the three-input voter stage. It takes one asynchronous serial line, oversamples each bit period `DIV` times and captures three adjacent mid-bit samples as a triplet. It computes the voted bit for each triplet and buffers triplet plus vote in a small FIFO with a valid/ready output handshake. Downstream logic consumes either the raw triplet (to drive a separate voter) or the voted bit directly.

## Interface
- `DIV`, 8: clock cycles per bit period; legal range 4..256.
- `DEPTH`, 4: output FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in 1: asynchronous serial line.
- `en` in 1: sampling enable.
- `trip` out 3: head-entry triplet; `trip[0]` is the earliest sample.
- `vote` out 1: head-entry voted bit.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: consumer accepts the head entry.
- `overflow` out 1: sticky flag; a push was dropped.
- `disagree` out 1: present only with `TRIPLET_DISAGREE_EN`.
- `err_cnt` out 8: present only with `TRIPLET_DISAGREE_EN`.

## Operation
- `din` passes through a 2-flop synchronizer (`din_s`) before any use.
- Phase counter `phase` has width clog2(`DIV`).
  - While `en`=0, `phase` is held at 0.
  - Each edge with `en`=1 increments `phase`, wrapping `DIV`-1 → 0.
- Sample capture on an edge with `en`=1:
  - `phase`==`DIV`/2-1 → `trip_r[0]`
  - `phase`==`DIV`/2 → `trip_r[1]`
  - `phase`==`DIV`/2+1 → `trip_r[2]`
  - Each capture takes the current `din_s`.
- Push: on an edge with `en`=1 and `phase`==`DIV`-1, the entry {`trip_r`, `vote3(trip_r)`} is pushed.
  - `vote3(a)` = a[0] ? (a[1]|a[2]) : (a[1]&a[2]), i.e. the majority of the three samples.
- FIFO behaviour:
  - Pop occurs when `out_valid`&&`out_ready`.
  - Push while full and no pop in the same edge: entry dropped, `overflow` set until `rst`.
  - Push and pop in the same edge while full: both succeed, occupancy unchanged, no overflow.
  - Push and pop in the same edge while empty: not possible, because a push becomes visible only on the next cycle.
- `en` falling mid-bit: `phase` returns to 0 on the next edge and the partial triplet is discarded. FIFO contents are kept and remain poppable.
- `rst` in any state clears everything: all outputs go to 0, FIFO is emptied, synchronizer is cleared.

## Timing
- Reset values: `trip`=3'b000, `vote`=0, `out_valid`=0, `overflow`=0, `disagree`=0, `err_cnt`=0.
- Input latency: `din` to `din_s` is 2 cycles. A sample taken at edge k reflects `din` as registered at edge k-2.
- With `en` high from edge 0, pushes occur at edges `DIV`-1, 2·`DIV`-1, …
- `out_valid` rises after the push edge when the FIFO was empty.
- Outputs `trip`, `vote` and `disagree` come directly from registers (FIFO head). No combinational path exists from `din` or `out_ready` to any output.
- Throughput: one entry per `DIV` cycles. The consumer may pop every cycle.

## Configuration
- `TRIPLET_DISAGREE_EN` defined:
  - Each entry carries `disagree` = (`trip_r` != 3'b000 && `trip_r` != 3'b111).
  - `err_cnt` increments on every accepted push with `disagree`=1 and saturates at 255.
  - Dropped pushes do not count.
- `TRIPLET_DISAGREE_EN` undefined:
  - Ports `disagree` and `err_cnt` are absent.
  - Entry width is 4 bits; no counter logic.

## Structure
- Package `triplet_pkg`:
  - `triplet_entry_t` struct {`trip`, `vote`, optional `disagree`}.
  - Function `vote3`.
  - Constant `ERR_CNT_W`=8.
- Sub-module `triplet_fifo`: parameterized synchronous FIFO of `triplet_entry_t` with full/empty flags, depth `DEPTH`.
- Top level holds the synchronizer, phase counter, capture registers, overflow flag and counter.

## Test plan
All scenarios use `DIV`=8, `DEPTH`=4.
- **Constant line.** `din`=1, `en`=1, `out_ready`=1 → one entry every 8 cycles with `trip`=3'b111, `vote`=1, `disagree`=0. First `out_valid` after edge 7.
- **Exhaustive patterns.** Drive `din` so the samples at phases 3, 4, 5 (after sync delay) form each of the 8 patterns → `vote` matches a[0]?(a[1]|a[2]):(a[1]&a[2]) every time. Pattern 3'b010 gives `vote`=0, `disagree`=1; after all 8 patterns, `err_cnt`=6.
- **Backpressure.** `out_ready`=0 for 5 bit periods → 4 entries retained in push order, `overflow`=1 after the 5th push edge. Then `out_ready`=1 → 4 pops, then `out_valid`=0; `overflow` stays 1.
- **Full with simultaneous pop.** FIFO full, `out_ready`=1 on the push edge → no overflow, occupancy stays 4.
- **Enable drop mid-bit.** Drop `en` at `phase`=4 for 3 cycles, then re-raise → no entry from the aborted bit; next push occurs 8 edges after re-enable; earlier entries remain.
- **Reset mid-operation.** Assert `rst` with 2 entries queued and `overflow`=1 → next cycle `out_valid`=0, `overflow`=0, `err_cnt`=0. First post-reset push 8 edges after `en` is sampled high.
